// File: rtl/serial_word_deserializer_if.sv
// Bundle of the serial input side and the parallel word output side of
// serial_word_deserializer; the deserializer uses the slave modport.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4
);
  // Handshake: a word transfers on any rising clk edge where word_valid and
  // word_ready are both 1. Once word_valid is 1, word_out stays stable until
  // that transfer happens. The serial side (si/si_valid/sof) has no back-pressure.
  logic             si;
  logic             si_valid;
  logic             sof;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output si, si_valid, sof, word_ready, clr_ovf,
    input  word_out, word_valid, overflow
  );

  modport slave (
    input  si, si_valid, sof, word_ready, clr_ovf,
    output word_out, word_valid, overflow
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Collects an MSB-first serial stream into WIDTH-bit words, held in a one-entry
// output register; words that complete while that register is still full are dropped.
module serial_word_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  serial_word_deserializer_if.slave   bus
);
  localparam int SW = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             overflow_q, overflow_d;

  logic             sof_hit;
  logic             complete;
  logic             writable;
  logic             drain;
  logic [WIDTH-1:0] word;

  always_comb begin
    sof_hit  = bus.si_valid & bus.sof;
    // A start-of-frame on the last bit position suppresses completion.
    complete = bus.si_valid & ~bus.sof & (cnt_q == CW'(WIDTH - 1));
    word     = {sreg_q, bus.si};
    writable = (state_q == EMPTY) | bus.word_ready;
    drain    = (state_q == FULL) & bus.word_ready;

    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    word_out_d = word_out_q;
    state_d    = state_q;
    overflow_d = overflow_q;

    if (bus.si_valid) begin
      // Bits shifted in before a sof fall off the top before the word completes.
      sreg_d = SW'({sreg_q, bus.si});
      if (sof_hit) begin
        cnt_d = CW'(1);
      end else if (complete) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (complete && writable) begin
      word_out_d = word;
      state_d    = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end

    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (complete && !writable) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      sreg_q     <= '0;
      cnt_q      <= '0;
      word_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      word_out_q <= word_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.word_out   = word_out_q;
  assign bus.word_valid = (state_q == FULL);
  assign bus.overflow   = overflow_q;
endmodule
